bitwise_sweep_gen: RTL

Operand sweep generator that sits directly upstream of the `bitwise` unit and drives its `a`/`b` operand inputs. It walks every pair `(a, b)` over two programmable inclusive ranges: `a` is the outer loop, `b` the inner loop. Each pair is presented under a valid/ready handshake, so a downstream capture or checker stage can apply backpressure. The block replaces hand-written nested stimulus loops with a reusable, synthesizable sequencer.

---
 rtl/bitwise_pkg.sv | 14 +
 rtl/bitwise_range_ctr.sv | 39 +++
 rtl/bitwise_sweep_gen.sv | 112 +++++++++++
 3 files changed

// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise operand path: default operand width,
// sweep sequencer states and the transfer-count width.
package bitwise_pkg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2*WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bitwise_range_ctr.sv
// Inclusive-range counter: latches lo/hi on cfg, reloads to lo or steps by one,
// and flags when the current value equals the latched hi bound.
module bitwise_range_ctr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg,
    input  logic             reload,
    input  logic             inc,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] value,
    output logic             at_hi
);

    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q  <= '0;
            hi_q  <= '0;
            value <= '0;
        end else if (cfg) begin
            lo_q  <= lo;
            hi_q  <= hi;
            value <= lo;
        end else if (reload) begin
            value <= lo_q;
        end else if (inc) begin
            value <= value + 1'b1;
        end
    end

    // End of range is an equality test, so hi = all-ones never relies on wrap.
    assign at_hi = (value == hi_q);

endmodule

// File: rtl/bitwise_sweep_gen.sv
// Operand sweep generator: walks every (a, b) pair over two inclusive ranges,
// a outer and b inner, presenting each pair under a valid/ready handshake.
module bitwise_sweep_gen
    import bitwise_pkg::*;
#(
    parameter int WIDTH = bitwise_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_lo,
    input  logic [WIDTH-1:0]     a_hi,
    input  logic [WIDTH-1:0]     b_lo,
    input  logic [WIDTH-1:0]     b_hi,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 last,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2*WIDTH:0]     count
);

    localparam int CW = 2*WIDTH + 1;

    // Handshake: a pair transfers on any edge where valid && ready; once valid
    // is raised, a_out/b_out/last/count stay put until that transfer happens.
    state_t state;
    state_t state_nxt;

    logic accept;
    logic ranges_ok;
    logic xfer;
    logic a_at_hi;
    logic b_at_hi;
    logic cfg;
    logic b_reload;
    logic b_inc;
    logic a_inc;

    assign accept    = (state == IDLE) && start;
    assign ranges_ok = (a_lo <= a_hi) && (b_lo <= b_hi);
    assign xfer      = valid && ready;
    assign cfg       = accept && ranges_ok;
    assign b_inc     = xfer && !b_at_hi;
    assign b_reload  = xfer && b_at_hi && !a_at_hi;
    assign a_inc     = b_reload;

    bitwise_range_ctr #(.WIDTH(WIDTH)) u_b_ctr (
        .clk    (clk),
        .rst    (rst),
        .cfg    (cfg),
        .reload (b_reload),
        .inc    (b_inc),
        .lo     (b_lo),
        .hi     (b_hi),
        .value  (b_out),
        .at_hi  (b_at_hi)
    );

    bitwise_range_ctr #(.WIDTH(WIDTH)) u_a_ctr (
        .clk    (clk),
        .rst    (rst),
        .cfg    (cfg),
        .reload (1'b0),
        .inc    (a_inc),
        .lo     (a_lo),
        .hi     (a_hi),
        .value  (a_out),
        .at_hi  (a_at_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = ranges_ok ? RUN : DONE;
            RUN:  if (xfer && a_at_hi && b_at_hi) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid = (state == RUN);
        busy  = (state != IDLE);
        done  = (state == DONE);
        last  = valid && a_at_hi && b_at_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            count <= '0;
            err   <= !ranges_ok;
        end else if (xfer) begin
            count <= count + CW'(1);
        end
    end

endmodule
